// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit arbiter.
//   DATA_BIT_DEF : default character width (must match the Tx core)
//   arb_state_t  : arbiter FSM states
//   clog2_min1() : index width helper that never returns 0
package usart_pkg;

  localparam int DATA_BIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usart_rr_arbiter.sv
// Combinational round-robin pick for the USART transmit arbiter.
//   req        in  NUM_REQ  request vector
//   last_grant in  GW       most recently served requester (lowest priority)
//   gnt_id     out GW       selected requester; valid when gnt_any=1
//   gnt_any    out 1        at least one request present
// The request vector is doubled: the lower copy is masked to indices above
// last_grant, the upper copy is unmasked. The lowest set bit of the doubled
// vector is the wrap-around search starting at last_grant+1.
module usart_rr_arbiter
  import usart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      gnt_id,
  output logic               gnt_any
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign mask[gi] = (GW'(gi) > last_grant);
  end

  assign dbl     = {req, req & mask};
  assign gnt_any = |req;

  always_comb begin
    logic found;
    int   pick;
    found = 1'b0;
    pick  = 0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        pick  = i;
      end
    end
    // Hits in the upper copy fold back onto the real requester index.
    gnt_id = (pick >= NUM_REQ) ? GW'(pick - NUM_REQ) : GW'(pick);
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Shares one USART transmitter among NUM_REQ byte sources.
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per-requester byte valid (held until accepted)
//   req_data    : byte of requester i at [i*DATA_BIT +: DATA_BIT]
//   req_last    : last byte of a message (lock build only)
//   req_ready   : one-hot accept pulse to the granted requester (LOAD cycle)
//   tx_data/tx_valid/tx_ready : registered valid/ready stage to the Tx core
//   grant_id    : current or last granted requester
//   busy        : FSM not in IDLE
// Build option: define USART_TX_ARB_PACKET_LOCK_EN to keep the grant on one
// requester until it sends a byte flagged req_last.
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_BIT = DATA_BIT_DEF,
  localparam int GW       = clog2_min1(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BIT-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BIT-1:0]          tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [GW-1:0]                grant_id,
  output logic                         busy
);

  arb_state_t    state_reg;
  logic [GW-1:0] last_grant_reg;
  logic [GW-1:0] pick_id;
  logic          pick_any;
  logic          load_ok;

  usart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .gnt_id     (pick_id),
    .gnt_any    (pick_any)
  );

  assign load_ok = req_valid[grant_id];
  assign busy    = (state_reg != IDLE);

`ifdef USART_TX_ARB_PACKET_LOCK_EN
  logic last_flag_reg;
  logic lock_reg;   // set while a multi-byte message holds the grant

  // While locked and waiting for the next byte, no accept pulse is shown.
  always_comb begin
    req_ready = '0;
    if (state_reg == LOAD && load_ok) req_ready[grant_id] = 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb begin
    req_ready = '0;
    if (state_reg == LOAD) req_ready[grant_id] = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_id       <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      tx_data        <= '0;
      tx_valid       <= 1'b0;
`ifdef USART_TX_ARB_PACKET_LOCK_EN
      last_flag_reg  <= 1'b0;
      lock_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_id;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (load_ok) begin
            tx_data   <= req_data[grant_id*DATA_BIT +: DATA_BIT];
            tx_valid  <= 1'b1;
            state_reg <= SEND;
`ifdef USART_TX_ARB_PACKET_LOCK_EN
            last_flag_reg <= req_last[grant_id];
          end else if (!lock_reg) begin
`else
          end else begin
`endif
            // Requester withdrew valid: skip it and re-arbitrate.
            last_grant_reg <= grant_id;
            state_reg      <= IDLE;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid       <= 1'b0;
            last_grant_reg <= grant_id;
`ifdef USART_TX_ARB_PACKET_LOCK_EN
            if (!last_flag_reg) begin
              lock_reg  <= 1'b1;
              state_reg <= LOAD;
            end else begin
              lock_reg  <= 1'b0;
              state_reg <= IDLE;
            end
`else
            state_reg <= IDLE;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
